// File: rtl/radar_pulse_sched.sv
// Round-robin pulse/PRI scheduler driving judge/wave_sel/f_word to the DDS generator bank.
// Optional build macro SCHED_FRAME_LIMIT_EN adds frame_limit: auto-stop after N frames.
module radar_pulse_sched #(
    parameter int NSLOT = 4,
    parameter int CNT_W = 24
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cfg_we,
    input  logic [$clog2(NSLOT)+1:0]   cfg_addr,
    input  logic [31:0]                cfg_wdata,
    input  logic                       start,
    input  logic                       stop,
`ifdef SCHED_FRAME_LIMIT_EN
    input  logic [15:0]                frame_limit,
`endif
    output logic                       busy,
    output logic                       judge,
    output logic [5:0]                 wave_sel,
    output logic [31:0]                f_word,
    output logic                       pulse_start,
    output logic                       pulse_active,
    output logic [$clog2(NSLOT)-1:0]   slot_idx,
    output logic                       frame_done
);
    localparam int SW = $clog2(NSLOT);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_PULSE, S_GAP} state_t;

    state_t            state_q;
    logic [NSLOT-1:0]  en_q;
    logic [5:0]        ws_q  [NSLOT];
    logic [31:0]       fw_q  [NSLOT];
    logic [CNT_W-1:0]  pw_q  [NSLOT];
    logic [CNT_W-1:0]  pri_q [NSLOT];

    logic [CNT_W-1:0]  cur_pw_q, cur_pri_q, cnt_q;
    logic [SW-1:0]     ptr_q, slot_idx_q;
    logic              stop_pend_q;
    logic              busy_q, judge_q, pulse_start_q, pulse_active_q, frame_done_q;
    logic [5:0]        wave_sel_q;
    logic [31:0]       f_word_q;

    logic [SW-1:0]     cfg_slot;
    logic [SW-1:0]     scan_slot;
    logic              scan_found, last_en, limit_hit;
    logic [CNT_W:0]    cnt_inc;
    logic              pulse_last, gap_last;

    assign cfg_slot   = cfg_addr[SW+1:2];
    assign cnt_inc    = {1'b0, cnt_q} + (CNT_W+1)'(1);
    assign pulse_last = cnt_inc >= {1'b0, cur_pw_q};
    assign gap_last   = cnt_inc >= {1'b0, cur_pri_q};

    // NOTE: every variable in an always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        scan_found = 1'b0;
        scan_slot  = ptr_q;
        for (int k = NSLOT - 1; k >= 0; k--) begin
            if (en_q[ptr_q + SW'(k)]) begin
                scan_found = 1'b1;
                scan_slot  = ptr_q + SW'(k);
            end
        end
    end

    // The playing slot closes a frame when no enabled slot sits above it.
    always_comb begin
        last_en = 1'b1;
        for (int s = 0; s < NSLOT; s++) begin
            if (en_q[s] && (SW'(s) > slot_idx_q)) last_en = 1'b0;
        end
    end

`ifdef SCHED_FRAME_LIMIT_EN
    logic [15:0] frame_cnt_q;
    assign limit_hit = last_en && (frame_limit != 16'd0) && (frame_cnt_q + 16'd1 == frame_limit);
`else
    assign limit_hit = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values; a same-cycle
    // config write and LOAD of one slot therefore sees the old descriptor.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= S_IDLE;
            // NOTE: descriptor storage is reset on purpose: after rst every slot must read as disabled.
            en_q           <= '0;
            for (int s = 0; s < NSLOT; s++) begin
                ws_q[s]  <= '0;
                fw_q[s]  <= '0;
                pw_q[s]  <= '0;
                pri_q[s] <= '0;
            end
            cur_pw_q       <= '0;
            cur_pri_q      <= '0;
            cnt_q          <= '0;
            ptr_q          <= '0;
            slot_idx_q     <= '0;
            stop_pend_q    <= 1'b0;
            busy_q         <= 1'b0;
            judge_q        <= 1'b1;
            pulse_start_q  <= 1'b0;
            pulse_active_q <= 1'b0;
            frame_done_q   <= 1'b0;
            wave_sel_q     <= '0;
            f_word_q       <= '0;
`ifdef SCHED_FRAME_LIMIT_EN
            frame_cnt_q    <= '0;
`endif
        end else begin
            pulse_start_q <= 1'b0;
            frame_done_q  <= 1'b0;

            if (cfg_we) begin
                case (cfg_addr[1:0])
                    2'd0: begin
                        en_q[cfg_slot] <= cfg_wdata[31];
                        ws_q[cfg_slot] <= cfg_wdata[5:0];
                    end
                    2'd1:    fw_q[cfg_slot]  <= cfg_wdata;
                    2'd2:    pw_q[cfg_slot]  <= cfg_wdata[CNT_W-1:0];
                    default: pri_q[cfg_slot] <= cfg_wdata[CNT_W-1:0];
                endcase
            end

            if (state_q != S_IDLE && stop) stop_pend_q <= 1'b1;

            case (state_q)
                S_IDLE: begin
                    if (start && !stop) begin
                        state_q     <= S_LOAD;
                        ptr_q       <= '0;
                        busy_q      <= 1'b1;
                        stop_pend_q <= 1'b0;
`ifdef SCHED_FRAME_LIMIT_EN
                        frame_cnt_q <= '0;
`endif
                    end
                end
                S_LOAD: begin
                    if (scan_found) begin
                        state_q        <= S_PULSE;
                        slot_idx_q     <= scan_slot;
                        cur_pw_q       <= pw_q[scan_slot];
                        cur_pri_q      <= pri_q[scan_slot];
                        cnt_q          <= '0;
                        judge_q        <= 1'b0;
                        wave_sel_q     <= ws_q[scan_slot];
                        f_word_q       <= fw_q[scan_slot];
                        pulse_start_q  <= 1'b1;
                        pulse_active_q <= 1'b1;
                    end else begin
                        state_q     <= S_IDLE;
                        busy_q      <= 1'b0;
                        stop_pend_q <= 1'b0;
                    end
                end
                S_PULSE: begin
                    cnt_q <= cnt_inc[CNT_W-1:0];
                    if (pulse_last) begin
                        state_q        <= S_GAP;
                        judge_q        <= 1'b1;
                        wave_sel_q     <= '0;
                        pulse_active_q <= 1'b0;
                    end
                end
                default: begin
                    cnt_q <= cnt_inc[CNT_W-1:0];
                    if (gap_last) begin
                        frame_done_q <= last_en;
`ifdef SCHED_FRAME_LIMIT_EN
                        if (last_en) frame_cnt_q <= frame_cnt_q + 16'd1;
`endif
                        if (stop_pend_q || stop || limit_hit) begin
                            state_q     <= S_IDLE;
                            busy_q      <= 1'b0;
                            stop_pend_q <= 1'b0;
                        end else begin
                            state_q <= S_LOAD;
                            ptr_q   <= slot_idx_q + SW'(1);
                        end
                    end
                end
            endcase
        end
    end

    assign busy         = busy_q;
    assign judge        = judge_q;
    assign wave_sel     = wave_sel_q;
    assign f_word       = f_word_q;
    assign pulse_start  = pulse_start_q;
    assign pulse_active = pulse_active_q;
    assign slot_idx     = slot_idx_q;
    assign frame_done   = frame_done_q;
endmodule
